// File: rtl/i2c_slave_if.sv
// Byte-stream side of the I2C target: received bytes out, transmit bytes in.
// Ports: outData/outValid/outReady, inData/inValid/inReady, busy, rdWr.
interface i2c_slave_if;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;
    logic       busy;
    logic       rdWr;

    modport slave (
        output outData, outValid, inReady, busy, rdWr,
        input  outReady, inData, inValid
    );

    modport master (
        input  outData, outValid, inReady, busy, rdWr,
        output outReady, inData, inValid
    );
endinterface

// File: rtl/i2c_slave.sv
// I2C target: address match, write bytes to a stream, read bytes from a stream.
// Ports: clock, reset (sync, high), sda (open-drain), scl (input), io (streams).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        sda,
    input  logic       scl,
    i2c_slave_if.slave io
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT
    } state_e;

    state_e     state, stateNext;
    logic       sdaS1, sdaS2, sdaD;
    logic       sclS1, sclS2, sclD;
    logic [2:0] bitCnt;
    logic [6:0] shiftReg;
    logic [7:0] txReg;
    logic [7:0] outDataQ;
    logic       outValidQ, inReadyQ, busyQ, rdWrQ;
    logic       slotLive, rxAck, sdaOe;

    // Synchronizers carry no reset so edge detection reflects the live
    // bus immediately after reset; no false START when reset drops.
    always_ff @(posedge clock) begin
        sdaS1 <= sda;
        sdaS2 <= sdaS1;
        sdaD  <= sdaS2;
        sclS1 <= scl;
        sclS2 <= sclS1;
        sclD  <= sclS2;
    end

    wire       sclRise = sclS2 & ~sclD;
    wire       sclFall = ~sclS2 & sclD;
    wire       start   = sclS2 & sclD & sdaD & ~sdaS2;
    wire       stop    = sclS2 & sclD & ~sdaD & sdaS2;
    wire       lastBit = (bitCnt == 3'd7);
    wire [7:0] shiftIn = {shiftReg, sdaS2};
    wire       addrHit = (shiftIn[7:1] == SLAVE_ADDR)
                       && (shiftIn[7:1] != 7'h00);
    wire       txFire  = inReadyQ & io.inValid;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (start) begin
            stateNext = ADDR;
        end else if (stop) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:     stateNext = IDLE;
                ADDR:     if (sclRise && lastBit)
                              stateNext = addrHit ? ADDR_ACK : IDLE;
                ADDR_ACK: if (sclFall && slotLive)
                              stateNext = rdWrQ ? TX : RX;
                RX:       if (sclRise && lastBit) stateNext = RX_ACK;
                RX_ACK:   if (sclFall && slotLive) stateNext = RX;
                TX:       if (sclFall && lastBit) stateNext = TX_ACK;
                TX_ACK:   if (sclRise && sdaS2) stateNext = WAIT;
                          else if (sclFall)     stateNext = TX;
                WAIT:     stateNext = WAIT;
            endcase
        end
    end

    // ACK slots open on the first falling edge after entry (slotLive)
    // and close on the second.
    always_comb begin
        sdaOe = 1'b0;
        unique case (state)
            ADDR_ACK: sdaOe = slotLive;
            RX_ACK:   sdaOe = slotLive & rxAck;
            TX:       sdaOe = ~txReg[3'd7 - bitCnt];
            default:  sdaOe = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bitCnt    <= 3'd0;
            shiftReg  <= 7'd0;
            txReg     <= 8'h00;
            outDataQ  <= 8'h00;
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b0;
            busyQ     <= 1'b0;
            rdWrQ     <= 1'b0;
            slotLive  <= 1'b0;
            rxAck     <= 1'b0;
        end else begin
            if (outValidQ && io.outReady) outValidQ <= 1'b0;
            // Fetch window closes on the next SCL fall; idle bus reads 0xFF.
            if (txFire) begin
                txReg    <= io.inData;
                inReadyQ <= 1'b0;
            end else if (inReadyQ && sclFall) begin
                txReg    <= 8'hFF;
                inReadyQ <= 1'b0;
            end
            if (start) begin
                bitCnt   <= 3'd0;
                busyQ    <= 1'b0;
                inReadyQ <= 1'b0;
                slotLive <= 1'b0;
            end else if (stop) begin
                busyQ    <= 1'b0;
                inReadyQ <= 1'b0;
                slotLive <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (sclRise) begin
                        shiftReg <= shiftIn[6:0];
                        bitCnt   <= bitCnt + 3'd1;
                        if (lastBit && addrHit) begin
                            rdWrQ    <= sdaS2;
                            busyQ    <= 1'b1;
                            inReadyQ <= sdaS2;
                            slotLive <= 1'b0;
                        end
                    end
                    RX: if (sclRise) begin
                        shiftReg <= shiftIn[6:0];
                        bitCnt   <= bitCnt + 3'd1;
                        if (lastBit) begin
                            slotLive <= 1'b0;
                            rxAck    <= ~outValidQ;
                            if (!outValidQ) begin
                                outDataQ  <= shiftIn;
                                outValidQ <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK, RX_ACK:
                        if (sclFall) slotLive <= 1'b1;
                    TX:
                        if (sclFall) bitCnt <= bitCnt + 3'd1;
                    TX_ACK:
                        if (sclRise && !sdaS2) inReadyQ <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign sda         = sdaOe ? 1'b0 : 1'bz;
    assign io.outData  = outDataQ;
    assign io.outValid = outValidQ;
    assign io.inReady  = inReadyQ;
    assign io.busy     = busyQ;
    assign io.rdWr     = rdWrQ;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master, stream source and sink.
// Drives scl/sda with an open-drain master model and checks stream outputs.
module tb_i2c_slave;

    localparam int Q = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl   = 1'b1;
    logic mLow  = 1'b0;
    logic provEn = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = mLow ? 1'b0 : 1'bz;

    i2c_slave_if bus ();

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clock (clock),
        .reset (reset),
        .sda   (sda),
        .scl   (scl),
        .io    (bus.slave)
    );

    always #5 clock = ~clock;

    int nCmp = 0;
    int nErr = 0;
    int slaveLow = 0;
    int ovCnt = 0;
    int irCnt = 0;
    int rxN = 0;
    int provIdx = 0;
    logic [7:0] rxLog [16];
    logic [7:0] provData [4] = '{8'hC3, 8'h5A, 8'h0F, 8'h00};

    // Master pins move on negedges, so posedge sees a stable master.
    always @(posedge clock)
        if (!sda && !mLow) slaveLow++;

    always @(negedge clock) begin
        if (bus.outValid) ovCnt++;
        if (bus.inReady) irCnt++;
        if (bus.outValid && bus.outReady) begin
            rxLog[rxN % 16] = bus.outData;
            rxN++;
        end
    end

    always @(negedge clock) begin
        if (!provEn) begin
            bus.inValid = 1'b0;
            bus.inData  = 8'h00;
        end else if (bus.inValid && !bus.inReady) begin
            bus.inValid = 1'b0;
        end else if (bus.inReady && !bus.inValid) begin
            bus.inData  = provData[provIdx];
            provIdx     = (provIdx + 1) % 4;
            bus.inValid = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic startCond();
        mLow = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        mLow = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic stopCond();
        mLow = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        mLow = 1'b0;
        tick(Q);
    endtask

    task automatic clockBit(input logic b, output logic seen);
        mLow = ~b;
        tick(Q);
        scl = 1'b1;
        tick(Q / 2);
        seen = sda;
        tick(Q / 2);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(d[i], s);
        clockBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic readByte(input logic mAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, s);
            d[i] = s;
        end
        clockBit(~mAck, s);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         n0, r0, l0, i0;

        bus.outReady = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(2);
        check("rst sda", sda, 1);
        check("rst outValid", bus.outValid, 0);
        check("rst outData", bus.outData, 8'h00);
        check("rst inReady", bus.inReady, 0);
        check("rst busy", bus.busy, 0);
        check("rst rdWr", bus.rdWr, 0);

        // write A5, 3C
        n0 = ovCnt;
        r0 = rxN;
        startCond();
        writeByte(8'hA0, ack);
        check("w addr ack", ack, 1);
        check("w busy", bus.busy, 1);
        writeByte(8'hA5, ack);
        check("w d0 ack", ack, 1);
        writeByte(8'h3C, ack);
        check("w d1 ack", ack, 1);
        stopCond();
        tick(8);
        check("w ov cycles", ovCnt - n0, 2);
        check("w rx count", rxN - r0, 2);
        check("w rx0", rxLog[r0 % 16], 8'hA5);
        check("w rx1", rxLog[(r0 + 1) % 16], 8'h3C);
        check("w busy stop", bus.busy, 0);

        // wrong address
        l0 = slaveLow;
        n0 = ovCnt;
        startCond();
        writeByte(8'hA2, ack);
        check("na addr ack", ack, 0);
        check("na busy", bus.busy, 0);
        writeByte(8'h11, ack);
        check("na d ack", ack, 0);
        stopCond();
        tick(8);
        check("na sda low", slaveLow - l0, 0);
        check("na ov", ovCnt - n0, 0);

        // read C3 then 5A with NACK
        provEn = 1'b1;
        startCond();
        writeByte(8'hA1, ack);
        check("r addr ack", ack, 1);
        check("r rdWr", bus.rdWr, 1);
        readByte(1'b1, d);
        check("r byte0", d, 8'hC3);
        readByte(1'b0, d);
        check("r byte1", d, 8'h5A);
        l0 = slaveLow;
        readByte(1'b0, d);
        check("r wait bus", d, 8'hFF);
        check("r wait low", slaveLow - l0, 0);
        check("r wait busy", bus.busy, 1);
        stopCond();
        tick(8);
        check("r busy stop", bus.busy, 0);
        provEn = 1'b0;

        // read with no source data
        i0 = irCnt;
        startCond();
        writeByte(8'hA1, ack);
        check("e addr ack", ack, 1);
        readByte(1'b0, d);
        check("e bus", d, 8'hFF);
        check("e inReady cycles", irCnt - i0, 10);
        stopCond();
        tick(8);

        // sink stalled
        bus.outReady = 1'b0;
        startCond();
        writeByte(8'hA0, ack);
        check("s addr ack", ack, 1);
        writeByte(8'h81, ack);
        check("s d0 ack", ack, 1);
        writeByte(8'h7E, ack);
        check("s d1 nack", ack, 0);
        stopCond();
        tick(4);
        check("s held data", bus.outData, 8'h81);
        check("s held valid", bus.outValid, 1);
        bus.outReady = 1'b1;
        tick(2);
        check("s drained", bus.outValid, 0);
        check("s data kept", bus.outData, 8'h81);

        // repeated START, then reset mid-byte
        startCond();
        writeByte(8'hA0, ack);
        check("rs rdWr0", bus.rdWr, 0);
        writeByte(8'h12, ack);
        check("rs d ack", ack, 1);
        provEn = 1'b1;
        startCond();
        check("rs busy clr", bus.busy, 0);
        writeByte(8'hA1, ack);
        check("rs addr ack", ack, 1);
        check("rs rdWr1", bus.rdWr, 1);
        check("rs busy", bus.busy, 1);
        clockBit(1'b1, s);
        check("rs tx bit7", s, 0);
        check("rs driving", sda, 0);
        reset = 1'b1;
        tick(1);
        check("rr sda", sda, 1);
        check("rr busy", bus.busy, 0);
        check("rr rdWr", bus.rdWr, 0);
        check("rr outData", bus.outData, 8'h00);
        check("rr inReady", bus.inReady, 0);
        reset = 1'b0;
        provEn = 1'b0;
        l0 = slaveLow;
        for (int i = 0; i < 3; i++) clockBit(1'b1, s);
        check("rr ignore", slaveLow - l0, 0);
        stopCond();
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nErr);
        $finish;
    end

endmodule
